// File: rtl/scarv_cop_issue_if.sv
// Bundle of pipeline-side and co-processor-side signals of the issuer.
// The master modport is the issuer itself; slave is the environment
// (host pipeline plus co-processor) that drives and observes it.
interface scarv_cop_issue_if;
    // Host pipeline instruction channel
    logic        pipe_valid;
    logic        pipe_ready;
    logic [31:0] pipe_insn;
    logic [31:0] pipe_rs1;
    logic        pipe_abort;

    // Host pipeline result channel
    logic        res_valid;
    logic        res_ready;
    logic        res_wen;
    logic [4:0]  res_waddr;
    logic [31:0] res_wdata;
    logic [2:0]  res_result;

    // Co-processor request channel
    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic        cpu_abort_req;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;

    // Co-processor response channel
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;

    modport master (
        input  pipe_valid, pipe_insn, pipe_rs1, pipe_abort, res_ready,
               cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result,
               cop_insn_rsp,
        output pipe_ready, res_valid, res_wen, res_waddr, res_wdata,
               res_result, cpu_insn_req, cpu_abort_req, cpu_insn_enc,
               cpu_rs1, cpu_insn_ack
    );

    modport slave (
        output pipe_valid, pipe_insn, pipe_rs1, pipe_abort, res_ready,
               cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result,
               cop_insn_rsp,
        input  pipe_ready, res_valid, res_wen, res_waddr, res_wdata,
               res_result, cpu_insn_req, cpu_abort_req, cpu_insn_enc,
               cpu_rs1, cpu_insn_ack
    );
endinterface

// File: rtl/scarv_cop_issue.sv
// CPU-side issuer for the Crypto ISE co-processor. Accepts one instruction
// from the pipeline, performs the request and response handshakes with the
// co-processor, and holds the write-back result until the pipeline takes it.
// Also forwards pipeline aborts and enforces a response timeout.
// Every output is a flop; nothing combinational reaches an output port.
module scarv_cop_issue #(
    parameter int TIMEOUT = 256
) (
    input  logic              g_clk,
    input  logic              g_resten,
    scarv_cop_issue_if.master bus
);
    localparam int              CW         = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic            TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [2:0]      RES_TIMEOUT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          pipe_ready_r;
    logic          cpu_insn_req_r;
    logic          cpu_insn_ack_r;
    logic          cpu_abort_req_r;
    logic          res_valid_r;
    logic          res_wen_r;
    logic [4:0]    res_waddr_r;
    logic [31:0]   res_wdata_r;
    logic [2:0]    res_result_r;
    logic [31:0]   cpu_insn_enc_r;
    logic [31:0]   cpu_rs1_r;
    logic          timeout_hit_s;

    // Last cycle the outstanding instruction may still complete its handshake
    assign timeout_hit_s = TIMEOUT_EN && (cnt_r == CNT_LAST);

    // Issue FSM; state flags, holding registers and abort pulse move together
    always_ff @(posedge g_clk or negedge g_resten) begin
        if (!g_resten) begin
            state_r         <= IDLE;
            cnt_r           <= '0;
            pipe_ready_r    <= 1'b1;
            cpu_insn_req_r  <= 1'b0;
            cpu_insn_ack_r  <= 1'b0;
            cpu_abort_req_r <= 1'b0;
            res_valid_r     <= 1'b0;
            res_wen_r       <= 1'b0;
            res_waddr_r     <= 5'd0;
            res_wdata_r     <= 32'd0;
            res_result_r    <= 3'd0;
            cpu_insn_enc_r  <= 32'd0;
            cpu_rs1_r       <= 32'd0;
        end else begin
            cpu_abort_req_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.pipe_valid) begin
                        cpu_insn_enc_r <= bus.pipe_insn;
                        cpu_rs1_r      <= bus.pipe_rs1;
                        cnt_r          <= '0;
                        pipe_ready_r   <= 1'b0;
                        cpu_insn_req_r <= 1'b1;
                        state_r        <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (bus.pipe_abort) begin
                        cpu_abort_req_r <= 1'b1;
                        cpu_insn_req_r  <= 1'b0;
                        pipe_ready_r    <= 1'b1;
                        state_r         <= IDLE;
                    end else if (bus.cop_insn_ack) begin
                        cpu_insn_req_r <= 1'b0;
                        cpu_insn_ack_r <= 1'b1;
                        state_r        <= WAIT;
                    end else if (timeout_hit_s) begin
                        cpu_abort_req_r <= 1'b1;
                        cpu_insn_req_r  <= 1'b0;
                        res_valid_r     <= 1'b1;
                        res_wen_r       <= 1'b0;
                        res_waddr_r     <= 5'd0;
                        res_wdata_r     <= 32'd0;
                        res_result_r    <= RES_TIMEOUT;
                        state_r         <= DONE;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (bus.pipe_abort) begin
                        // A coincident response still completes on the bus
                        // this cycle; its payload is simply not captured.
                        cpu_abort_req_r <= 1'b1;
                        cpu_insn_ack_r  <= 1'b0;
                        pipe_ready_r    <= 1'b1;
                        state_r         <= IDLE;
                    end else if (bus.cop_insn_rsp) begin
                        cpu_insn_ack_r <= 1'b0;
                        res_valid_r    <= 1'b1;
                        res_wen_r      <= bus.cop_wen;
                        res_waddr_r    <= bus.cop_waddr;
                        res_wdata_r    <= bus.cop_wdata;
                        res_result_r   <= bus.cop_result;
                        state_r        <= DONE;
                    end else if (timeout_hit_s) begin
                        cpu_abort_req_r <= 1'b1;
                        cpu_insn_ack_r  <= 1'b0;
                        res_valid_r     <= 1'b1;
                        res_wen_r       <= 1'b0;
                        res_waddr_r     <= 5'd0;
                        res_wdata_r     <= 32'd0;
                        res_result_r    <= RES_TIMEOUT;
                        state_r         <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r  <= 1'b0;
                        pipe_ready_r <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    cpu_insn_req_r <= 1'b0;
                    cpu_insn_ack_r <= 1'b0;
                    res_valid_r    <= 1'b0;
                    pipe_ready_r   <= 1'b1;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

    assign bus.pipe_ready    = pipe_ready_r;
    assign bus.cpu_insn_req  = cpu_insn_req_r;
    assign bus.cpu_insn_ack  = cpu_insn_ack_r;
    assign bus.cpu_abort_req = cpu_abort_req_r;
    assign bus.cpu_insn_enc  = cpu_insn_enc_r;
    assign bus.cpu_rs1       = cpu_rs1_r;
    assign bus.res_valid     = res_valid_r;
    assign bus.res_wen       = res_wen_r;
    assign bus.res_waddr     = res_waddr_r;
    assign bus.res_wdata     = res_wdata_r;
    assign bus.res_result    = res_result_r;
endmodule

// File: tb/tb_scarv_cop_issue.sv
// Directed testbench for scarv_cop_issue. Instance u0 uses the default
// timeout, instance u1 uses TIMEOUT=8 for the timeout scenarios.
// Cycle k is the interval just after the k-th rising edge of a scenario.
module tb_scarv_cop_issue;
    logic g_clk    = 1'b0;
    logic g_resten = 1'b0;
    int   n_cmp    = 0;
    int   n_err    = 0;

    scarv_cop_issue_if b0 ();
    scarv_cop_issue_if b1 ();

    scarv_cop_issue u0 (.g_clk(g_clk), .g_resten(g_resten), .bus(b0));
    scarv_cop_issue #(.TIMEOUT(8)) u1 (.g_clk(g_clk), .g_resten(g_resten), .bus(b1));

    always #5 g_clk = ~g_clk;

    // Advance one cycle and land just after the edge
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic clear_inputs();
        b0.pipe_valid = 1'b0; b0.pipe_insn = 32'd0; b0.pipe_rs1 = 32'd0;
        b0.pipe_abort = 1'b0; b0.res_ready = 1'b0;  b0.cop_insn_ack = 1'b0;
        b0.cop_wen = 1'b0; b0.cop_waddr = 5'd0; b0.cop_wdata = 32'd0;
        b0.cop_result = 3'd0; b0.cop_insn_rsp = 1'b0;
        b1.pipe_valid = 1'b0; b1.pipe_insn = 32'd0; b1.pipe_rs1 = 32'd0;
        b1.pipe_abort = 1'b0; b1.res_ready = 1'b0;  b1.cop_insn_ack = 1'b0;
        b1.cop_wen = 1'b0; b1.cop_waddr = 5'd0; b1.cop_wdata = 32'd0;
        b1.cop_result = 3'd0; b1.cop_insn_rsp = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0]   flags;
        logic [103:0] data;
        clear_inputs();
        g_resten = 1'b0;
        tick();
        flags = {b0.pipe_ready, b0.cpu_insn_req, b0.cpu_insn_ack,
                 b0.cpu_abort_req, b0.res_valid, b0.res_wen};
        data  = {b0.cpu_insn_enc, b0.cpu_rs1, b0.res_waddr, b0.res_wdata, b0.res_result};
        n_cmp++;
        if (flags !== 6'b100000) begin
            n_err++; $display("FAIL reset_flags got %b want %b", flags, 6'b100000);
        end
        n_cmp++;
        if (data !== 104'd0) begin
            n_err++; $display("FAIL reset_data got %h want 0", data);
        end
        n_cmp++;
        if ({b1.pipe_ready, b1.cpu_insn_req, b1.res_valid} !== 3'b100) begin
            n_err++; $display("FAIL reset_u1 got %b want 100",
                              {b1.pipe_ready, b1.cpu_insn_req, b1.res_valid});
        end
        g_resten = 1'b1;
        tick();
    endtask

    task automatic test_single();
        // cycle 0: accept
        n_cmp++;
        if (b0.pipe_ready !== 1'b1) begin
            n_err++; $display("FAIL single_ready0 got %b want 1", b0.pipe_ready);
        end
        b0.pipe_valid = 1'b1; b0.pipe_insn = 32'h0000_002B; b0.pipe_rs1 = 32'h1234_5678;
        tick();
        // cycle 1: request, co-processor acks
        b0.pipe_valid = 1'b0; b0.pipe_insn = 32'd0; b0.pipe_rs1 = 32'd0;
        n_cmp++;
        if ({b0.cpu_insn_req, b0.cpu_insn_enc, b0.cpu_rs1} !== {1'b1, 32'h0000_002B, 32'h1234_5678}) begin
            n_err++; $display("FAIL single_req got %b %h %h want 1 0000002b 12345678",
                              b0.cpu_insn_req, b0.cpu_insn_enc, b0.cpu_rs1);
        end
        b0.cop_insn_ack = 1'b1;
        tick();
        // cycle 2: response
        b0.cop_insn_ack = 1'b0;
        n_cmp++;
        if ({b0.cpu_insn_ack, b0.cpu_insn_req, b0.res_valid} !== 3'b100) begin
            n_err++; $display("FAIL single_wait got %b want 100",
                              {b0.cpu_insn_ack, b0.cpu_insn_req, b0.res_valid});
        end
        b0.cop_insn_rsp = 1'b1; b0.cop_wen = 1'b1; b0.cop_waddr = 5'd5;
        b0.cop_wdata = 32'hDEAD_BEEF; b0.cop_result = 3'd0;
        tick();
        // cycle 3: result held
        b0.cop_insn_rsp = 1'b0; b0.cop_wen = 1'b0; b0.cop_waddr = 5'd0; b0.cop_wdata = 32'd0;
        n_cmp++;
        if ({b0.res_valid, b0.res_wen, b0.res_waddr, b0.res_wdata, b0.res_result} !==
            {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0}) begin
            n_err++; $display("FAIL single_res got v=%b wen=%b a=%0d d=%h r=%0d want 1 1 5 deadbeef 0",
                              b0.res_valid, b0.res_wen, b0.res_waddr, b0.res_wdata, b0.res_result);
        end
        n_cmp++;
        if ({b0.pipe_ready, b0.cpu_insn_ack} !== 2'b00) begin
            n_err++; $display("FAIL single_done_flags got %b want 00", {b0.pipe_ready, b0.cpu_insn_ack});
        end
        b0.res_ready = 1'b1;
        tick();
        // cycle 4: back in IDLE
        b0.res_ready = 1'b0;
        n_cmp++;
        if ({b0.pipe_ready, b0.res_valid} !== 2'b10) begin
            n_err++; $display("FAIL single_idle got %b want 10", {b0.pipe_ready, b0.res_valid});
        end
    endtask

    task automatic test_backpressure();
        // cycle 0: accept straight after the previous transaction
        b0.pipe_valid = 1'b1; b0.pipe_insn = 32'hA5A5_0001; b0.pipe_rs1 = 32'h0F0F_F0F0;
        tick();
        b0.pipe_valid = 1'b0; b0.pipe_insn = 32'hFFFF_FFFF; b0.pipe_rs1 = 32'hFFFF_FFFF;
        // cycles 1..5: request held; ack arrives in cycle 5
        for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if ({b0.cpu_insn_req, b0.cpu_insn_enc, b0.cpu_rs1} !== {1'b1, 32'hA5A5_0001, 32'h0F0F_F0F0}) begin
                n_err++; $display("FAIL bp_req_stable cyc%0d got %b %h %h want 1 a5a50001 0f0ff0f0",
                                  i, b0.cpu_insn_req, b0.cpu_insn_enc, b0.cpu_rs1);
            end
            if (i == 5) b0.cop_insn_ack = 1'b1;
            tick();
        end
        b0.cop_insn_ack = 1'b0;
        // cycles 6..12: waiting; response arrives in cycle 12
        for (int i = 6; i <= 12; i++) begin
            n_cmp++;
            if ({b0.cpu_insn_ack, b0.cpu_insn_req, b0.res_valid} !== 3'b100) begin
                n_err++; $display("FAIL bp_wait cyc%0d got %b want 100",
                                  i, {b0.cpu_insn_ack, b0.cpu_insn_req, b0.res_valid});
            end
            if (i == 12) begin
                b0.cop_insn_rsp = 1'b1; b0.cop_wen = 1'b1; b0.cop_waddr = 5'd31;
                b0.cop_wdata = 32'h0BAD_F00D; b0.cop_result = 3'b010;
            end
            tick();
        end
        // cycles 13..16: result held while inputs wander; consumed in cycle 16
        for (int i = 13; i <= 16; i++) begin
            b0.cop_insn_rsp = 1'b0; b0.cop_wen = 1'b0;
            b0.cop_waddr = 5'(i); b0.cop_wdata = 32'(i); b0.cop_result = 3'b101;
            n_cmp++;
            if ({b0.res_valid, b0.res_wen, b0.res_waddr, b0.res_wdata, b0.res_result} !==
                {1'b1, 1'b1, 5'd31, 32'h0BAD_F00D, 3'b010}) begin
                n_err++; $display("FAIL bp_res_stable cyc%0d got v=%b wen=%b a=%0d d=%h r=%0d want 1 1 31 0badf00d 2",
                                  i, b0.res_valid, b0.res_wen, b0.res_waddr, b0.res_wdata, b0.res_result);
            end
            if (i == 16) b0.res_ready = 1'b1;
            tick();
        end
        b0.res_ready = 1'b0; b0.cop_waddr = 5'd0; b0.cop_wdata = 32'd0; b0.cop_result = 3'd0;
        n_cmp++;
        if ({b0.pipe_ready, b0.res_valid} !== 2'b10) begin
            n_err++; $display("FAIL bp_idle got %b want 10", {b0.pipe_ready, b0.res_valid});
        end
    endtask

    task automatic test_abort_wait();
        int n_ab;
        int n_rv;
        b0.pipe_valid = 1'b1; b0.pipe_insn = 32'h0000_0101; b0.pipe_rs1 = 32'd7;
        tick();
        b0.pipe_valid = 1'b0; b0.cop_insn_ack = 1'b1;   // cycle 1: ack
        tick();
        b0.cop_insn_ack = 1'b0;                           // cycle 2
        tick();
        // cycle 3: abort two cycles after the ack
        n_cmp++;
        if ({b0.cpu_insn_ack, b0.cpu_abort_req} !== 2'b10) begin
            n_err++; $display("FAIL abw_pre got %b want 10", {b0.cpu_insn_ack, b0.cpu_abort_req});
        end
        b0.pipe_abort = 1'b1;
        tick();
        b0.pipe_abort = 1'b0;
        n_ab = 0; n_rv = 0;
        for (int i = 0; i < 4; i++) begin
            if (b0.cpu_abort_req === 1'b1) n_ab++;
            if (b0.res_valid === 1'b1) n_rv++;
            tick();
        end
        n_cmp++;
        if (n_ab !== 1) begin
            n_err++; $display("FAIL abw_pulses got %0d want 1", n_ab);
        end
        n_cmp++;
        if (n_rv !== 0) begin
            n_err++; $display("FAIL abw_res_valid got %0d cycles want 0", n_rv);
        end
        n_cmp++;
        if ({b0.pipe_ready, b0.cpu_insn_ack, b0.cpu_insn_req} !== 3'b100) begin
            n_err++; $display("FAIL abw_idle got %b want 100",
                              {b0.pipe_ready, b0.cpu_insn_ack, b0.cpu_insn_req});
        end
    endtask

    task automatic test_abort_rsp();
        int n_ab;
        int n_rv;
        b0.pipe_valid = 1'b1; b0.pipe_insn = 32'h0000_0202; b0.pipe_rs1 = 32'd9;
        tick();
        b0.pipe_valid = 1'b0; b0.cop_insn_ack = 1'b1;
        tick();
        // cycle 2: response and abort together
        b0.cop_insn_ack = 1'b0;
        b0.cop_insn_rsp = 1'b1; b0.cop_wen = 1'b1; b0.cop_waddr = 5'd3;
        b0.cop_wdata = 32'h1111_2222; b0.cop_result = 3'b001;
        b0.pipe_abort = 1'b1;
        n_cmp++;
        if (b0.cpu_insn_ack !== 1'b1) begin
            n_err++; $display("FAIL abr_ack got %b want 1", b0.cpu_insn_ack);
        end
        tick();
        b0.cop_insn_rsp = 1'b0; b0.cop_wen = 1'b0; b0.cop_waddr = 5'd0;
        b0.cop_wdata = 32'd0; b0.cop_result = 3'd0; b0.pipe_abort = 1'b0;
        n_ab = 0; n_rv = 0;
        for (int i = 0; i < 4; i++) begin
            if (b0.cpu_abort_req === 1'b1) n_ab++;
            if (b0.res_valid === 1'b1) n_rv++;
            tick();
        end
        n_cmp++;
        if ({n_ab, n_rv} !== {32'd1, 32'd0}) begin
            n_err++; $display("FAIL abr_pulses got abort=%0d res_valid=%0d want 1 0", n_ab, n_rv);
        end
        n_cmp++;
        if (b0.res_wdata !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL abr_discard got %h want 0badf00d", b0.res_wdata);
        end
    endtask

    task automatic test_abort_ignored();
        // IDLE: abort does nothing
        b0.pipe_abort = 1'b1;
        tick();
        b0.pipe_abort = 1'b0;
        n_cmp++;
        if ({b0.cpu_abort_req, b0.pipe_ready, b0.cpu_insn_req} !== 3'b010) begin
            n_err++; $display("FAIL abi_idle got %b want 010",
                              {b0.cpu_abort_req, b0.pipe_ready, b0.cpu_insn_req});
        end
        // Run to DONE, then abort there
        b0.pipe_valid = 1'b1; b0.pipe_insn = 32'h0000_0303;
        tick();
        b0.pipe_valid = 1'b0; b0.cop_insn_ack = 1'b1;
        tick();
        b0.cop_insn_ack = 1'b0; b0.cop_insn_rsp = 1'b1; b0.cop_wen = 1'b1;
        b0.cop_waddr = 5'd12; b0.cop_wdata = 32'h5555_AAAA; b0.cop_result = 3'b011;
        tick();
        b0.cop_insn_rsp = 1'b0; b0.cop_wen = 1'b0;
        b0.pipe_abort = 1'b1;
        tick();
        b0.pipe_abort = 1'b0;
        n_cmp++;
        if ({b0.res_valid, b0.cpu_abort_req, b0.res_waddr, b0.res_wdata} !==
            {1'b1, 1'b0, 5'd12, 32'h5555_AAAA}) begin
            n_err++; $display("FAIL abi_done got v=%b ab=%b a=%0d d=%h want 1 0 12 5555aaaa",
                              b0.res_valid, b0.cpu_abort_req, b0.res_waddr, b0.res_wdata);
        end
        b0.res_ready = 1'b1;
        tick();
        b0.res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        // Response in the last allowed cycle (cycle 8) still wins
        b1.pipe_valid = 1'b1; b1.pipe_insn = 32'h0000_105B; b1.pipe_rs1 = 32'h0000_CAFE;
        tick();
        b1.pipe_valid = 1'b0; b1.cop_insn_ack = 1'b1;    // cycle 1
        tick();
        b1.cop_insn_ack = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            n_cmp++;
            if ({b1.cpu_insn_ack, b1.res_valid} !== 2'b10) begin
                n_err++; $display("FAIL to_late_wait cyc%0d got %b want 10",
                                  i, {b1.cpu_insn_ack, b1.res_valid});
            end
            if (i == 8) begin
                b1.cop_insn_rsp = 1'b1; b1.cop_wen = 1'b1; b1.cop_waddr = 5'd7;
                b1.cop_wdata = 32'hFFFF_FFFF; b1.cop_result = 3'b001;
            end
            tick();
        end
        b1.cop_insn_rsp = 1'b0; b1.cop_wen = 1'b0; b1.cop_waddr = 5'd0;
        b1.cop_wdata = 32'd0; b1.cop_result = 3'd0;
        n_cmp++;
        if ({b1.res_valid, b1.res_wen, b1.res_waddr, b1.res_wdata, b1.res_result, b1.cpu_abort_req} !==
            {1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 3'b001, 1'b0}) begin
            n_err++; $display("FAIL to_late_res got v=%b wen=%b a=%0d d=%h r=%0d ab=%b want 1 1 7 ffffffff 1 0",
                              b1.res_valid, b1.res_wen, b1.res_waddr, b1.res_wdata, b1.res_result, b1.cpu_abort_req);
        end
        b1.res_ready = 1'b1;
        tick();
        b1.res_ready = 1'b0;
        // Co-processor never acks: timeout in cycle 8, result in cycle 9
        b1.pipe_valid = 1'b1; b1.pipe_insn = 32'h0000_205B; b1.pipe_rs1 = 32'd1;
        tick();
        b1.pipe_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if ({b1.cpu_insn_req, b1.res_valid, b1.cpu_abort_req} !== 3'b100) begin
                n_err++; $display("FAIL to_req cyc%0d got %b want 100",
                                  i, {b1.cpu_insn_req, b1.res_valid, b1.cpu_abort_req});
            end
            tick();
        end
        n_cmp++;
        if ({b1.res_valid, b1.res_wen, b1.res_waddr, b1.res_wdata, b1.res_result} !==
            {1'b1, 1'b0, 5'd0, 32'd0, 3'b111}) begin
            n_err++; $display("FAIL to_res got v=%b wen=%b a=%0d d=%h r=%b want 1 0 0 0 111",
                              b1.res_valid, b1.res_wen, b1.res_waddr, b1.res_wdata, b1.res_result);
        end
        n_cmp++;
        if ({b1.cpu_abort_req, b1.cpu_insn_req} !== 2'b10) begin
            n_err++; $display("FAIL to_abort got %b want 10", {b1.cpu_abort_req, b1.cpu_insn_req});
        end
        tick();
        n_cmp++;
        if ({b1.cpu_abort_req, b1.res_valid} !== 2'b01) begin
            n_err++; $display("FAIL to_abort_end got %b want 01", {b1.cpu_abort_req, b1.res_valid});
        end
        b1.res_ready = 1'b1;
        tick();
        b1.res_ready = 1'b0;
        n_cmp++;
        if (b1.pipe_ready !== 1'b1) begin
            n_err++; $display("FAIL to_idle got %b want 1", b1.pipe_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [5:0]   flags;
        logic [103:0] data;
        b0.pipe_valid = 1'b1; b0.pipe_insn = 32'h0000_0404; b0.pipe_rs1 = 32'h0000_0044;
        tick();
        b0.pipe_valid = 1'b0; b0.cop_insn_ack = 1'b1;
        tick();
        b0.cop_insn_ack = 1'b0;
        n_cmp++;
        if (b0.cpu_insn_ack !== 1'b1) begin
            n_err++; $display("FAIL rst_wait got %b want 1", b0.cpu_insn_ack);
        end
        // Asynchronous reset inside the cycle
        g_resten = 1'b0;
        #1;
        flags = {b0.pipe_ready, b0.cpu_insn_req, b0.cpu_insn_ack,
                 b0.cpu_abort_req, b0.res_valid, b0.res_wen};
        data  = {b0.cpu_insn_enc, b0.cpu_rs1, b0.res_waddr, b0.res_wdata, b0.res_result};
        n_cmp++;
        if ({flags, data} !== {6'b100000, 104'd0}) begin
            n_err++; $display("FAIL rst_async got flags=%b data=%h want 100000 0", flags, data);
        end
        tick();
        g_resten = 1'b1;
        tick();
        n_cmp++;
        if ({b0.cpu_abort_req, b0.pipe_ready} !== 2'b01) begin
            n_err++; $display("FAIL rst_no_abort got %b want 01", {b0.cpu_abort_req, b0.pipe_ready});
        end
        // Normal transaction afterwards
        b0.pipe_valid = 1'b1; b0.pipe_insn = 32'h0000_0505; b0.pipe_rs1 = 32'h0000_0055;
        tick();
        b0.pipe_valid = 1'b0; b0.cop_insn_ack = 1'b1;
        tick();
        b0.cop_insn_ack = 1'b0; b0.cop_insn_rsp = 1'b1; b0.cop_wen = 1'b1;
        b0.cop_waddr = 5'd9; b0.cop_wdata = 32'hC0DE_0009; b0.cop_result = 3'b100;
        tick();
        b0.cop_insn_rsp = 1'b0; b0.cop_wen = 1'b0; b0.cop_waddr = 5'd0;
        b0.cop_wdata = 32'd0; b0.cop_result = 3'd0;
        n_cmp++;
        if ({b0.res_valid, b0.res_wen, b0.res_waddr, b0.res_wdata, b0.res_result, b0.cpu_insn_enc} !==
            {1'b1, 1'b1, 5'd9, 32'hC0DE_0009, 3'b100, 32'h0000_0505}) begin
            n_err++; $display("FAIL rst_after got v=%b wen=%b a=%0d d=%h r=%b enc=%h want 1 1 9 c0de0009 100 00000505",
                              b0.res_valid, b0.res_wen, b0.res_waddr, b0.res_wdata, b0.res_result, b0.cpu_insn_enc);
        end
        b0.res_ready = 1'b1;
        tick();
        b0.res_ready = 1'b0;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_abort_wait();
        test_abort_rsp();
        test_abort_ignored();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
